// File: rtl/float_div_chunked.sv
// Multi-cycle IEEE-754 single-precision divider: restoring division, div_bits_per_cycle quotient bits per clock.
// Optional FLOAT_DIV_SATURATE_EN clamps out-of-range exponents to inf/zero instead of wrapping the field.
module float_div_chunked #(
  parameter int float_width        = 32,
  parameter int float_exp_width    = 8,
  parameter int float_mant_width   = 23,
  parameter int div_bits_per_cycle = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic [float_width-1:0] a,
  input  logic [float_width-1:0] b,
  output logic                   ack,
  output logic [float_width-1:0] out
);
  // state | meaning
  // IDLE  | waiting for req; special cases answered directly from here
  // DIV   | resolving div_bits_per_cycle quotient bits per clock
  // NORM  | normalise quotient, pack result, pulse ack
  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  localparam int qw         = float_mant_width + 2;
  localparam int div_cycles = qw / div_bits_per_cycle;
  localparam int cnt_w      = $clog2(div_cycles + 1);
  localparam int mw         = float_mant_width + 1;
`ifdef FLOAT_DIV_SATURATE_EN
  localparam int ew = float_exp_width + 2;
`else
  // Without range checking only the low field bits are ever observed, so modulo arithmetic suffices.
  localparam int ew = float_exp_width;
`endif
  localparam logic [ew-1:0] bias = ew'((1 << (float_exp_width - 1)) - 1);

  state_t                 state, state_n;
  logic [qw-1:0]          rem, rem_n, q;
  logic [mw-1:0]          mb;
  logic signed [ew-1:0]   exp_w, exp_fin;
  logic                   sign;
  logic [cnt_w-1:0]       cnt;
  logic [div_bits_per_cycle-1:0] bits;
  logic [float_mant_width-1:0]   mant;
  logic [float_width-1:0]        out_norm;

  logic [float_exp_width-1:0] a_exp, b_exp;
  logic a_zero, b_zero, sign_in;

  assign a_exp   = a[float_width-2 -: float_exp_width];
  assign b_exp   = b[float_width-2 -: float_exp_width];
  assign a_zero  = (a_exp == '0);
  assign b_zero  = (b_exp == '0);
  assign sign_in = a[float_width-1] ^ b[float_width-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (req && !a_zero && !b_zero) state_n = DIV;
      DIV:  if (cnt == cnt_w'(div_cycles - 1)) state_n = NORM;
      NORM: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rem_n = rem;
    bits  = '0;
    for (int i = 0; i < div_bits_per_cycle; i++) begin
      if (rem_n >= {1'b0, mb}) begin
        rem_n = rem_n - {1'b0, mb};
        bits[div_bits_per_cycle-1-i] = 1'b1;
      end
      rem_n = rem_n << 1;
    end
  end

  always_comb begin
    if (q[qw-1]) begin
      mant    = q[qw-2:1];
      exp_fin = exp_w;
    end else begin
      mant    = q[qw-3:0];
      exp_fin = exp_w - ew'(1);
    end
    out_norm = {sign, exp_fin[float_exp_width-1:0], mant};
`ifdef FLOAT_DIV_SATURATE_EN
    if (exp_fin >= $signed(ew'((1 << float_exp_width) - 1)))
      out_norm = {sign, {float_exp_width{1'b1}}, {float_mant_width{1'b0}}};
    else if (exp_fin <= $signed(ew'(0)))
      out_norm = {sign, {(float_width-1){1'b0}}};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack   <= 1'b0;
      out   <= '0;
      rem   <= '0;
      q     <= '0;
      mb    <= '0;
      exp_w <= '0;
      sign  <= 1'b0;
      cnt   <= '0;
    end else begin
      ack <= 1'b0;
      out <= '0;
      case (state)
        IDLE: if (req) begin
          sign <= sign_in;
          if (a_zero) begin
            ack <= 1'b1;
            out <= {sign_in, {(float_width-1){1'b0}}};
          end else if (b_zero) begin
            ack <= 1'b1;
            out <= {sign_in, {float_exp_width{1'b1}}, {float_mant_width{1'b0}}};
          end else begin
            mb    <= {1'b1, b[float_mant_width-1:0]};
            rem   <= {2'b01, a[float_mant_width-1:0]};
            q     <= '0;
            cnt   <= '0;
            exp_w <= ew'(a_exp) - ew'(b_exp) + bias;
          end
        end
        DIV: begin
          rem <= rem_n;
          q   <= {q[qw-1-div_bits_per_cycle:0], bits};
          cnt <= cnt + cnt_w'(1);
        end
        NORM: begin
          ack <= 1'b1;
          out <= out_norm;
        end
        default: ;
      endcase
    end
  end
endmodule
